// File: rtl/i2c_sched_pkg.sv
// i2c_sched_pkg: shared FSM state, direction constants and write-request type
// for the I2C transaction scheduler.
package i2c_sched_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;
    localparam int REQ_ADDR_W = 8;
    localparam int REQ_DATA_W = 8;
    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] data;
    } wr_req_t;
endpackage

// File: rtl/i2c_sched_fifo.sv
// i2c_sched_fifo: synchronous FIFO; pointers carry one extra wrap bit so
// full/empty fall out of an MSB compare.
module i2c_sched_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wp_q, rp_q;
    assign empty_o = wp_q == rp_q;
    assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign dout_o  = mem_q[rp_q[AW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (push_i && !full_o) wp_q <= wp_q + (AW+1)'(1);
            if (pop_i && !empty_o) rp_q <= rp_q + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wp_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/i2c_txn_scheduler.sv
// i2c_txn_scheduler: queues AXI-side write/read requests, issues them one at a
// time round-robin to the I2C master. I2C_SCHED_TIMEOUT_EN adds a WAIT watchdog.
module i2c_txn_scheduler
    import i2c_sched_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int RDATA_W        = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               wr_req_valid,
    output logic               wr_req_ready,
    input  logic [ADDR_W-1:0]  wr_req_addr,
    input  logic [DATA_W-1:0]  wr_req_data,
    input  logic               rd_req_valid,
    output logic               rd_req_ready,
    input  logic [ADDR_W-1:0]  rd_req_addr,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic               cmd_rw,
    output logic [ADDR_W-1:0]  cmd_addr,
    output logic [DATA_W-1:0]  cmd_wdata,
    output logic               i2c_trigger,
    output logic               cmd_abort,
    input  logic               done,
    input  logic               done_nack,
    input  logic [RDATA_W-1:0] done_rdata,
    output logic               wr_resp_valid,
    input  logic               wr_resp_ready,
    output logic               wr_resp_err,
    output logic               rd_resp_valid,
    input  logic               rd_resp_ready,
    output logic [RDATA_W-1:0] rd_resp_data,
    output logic               rd_resp_err,
    output logic               pending_wr,
    output logic               pending_rd,
    output logic               busy
);
    logic                     wr_full, wr_empty, rd_full, rd_empty, wr_pop, rd_pop;
    logic [ADDR_W+DATA_W-1:0] wr_head;
    logic [ADDR_W-1:0]        rd_head;
    logic                     init_q, wr_avail_q, rd_avail_q, last_grant_q, grant_rd, timeout;
    state_t                   state_q;
    logic                     cmd_valid_q, cmd_rw_q, trig_q, err_q, wr_resp_valid_q, rd_resp_valid_q;
    logic [ADDR_W-1:0]        cmd_addr_q;
    logic [DATA_W-1:0]        cmd_wdata_q;
    logic [RDATA_W-1:0]       rdata_q;

    i2c_sched_fifo #(.W(ADDR_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk(ACLK), .rst(ARESET), .push_i(wr_req_valid && init_q),
        .din_i({wr_req_addr, wr_req_data}), .pop_i(wr_pop),
        .dout_o(wr_head), .full_o(wr_full), .empty_o(wr_empty)
    );
    i2c_sched_fifo #(.W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk(ACLK), .rst(ARESET), .push_i(rd_req_valid && init_q),
        .din_i(rd_req_addr), .pop_i(rd_pop),
        .dout_o(rd_head), .full_o(rd_full), .empty_o(rd_empty)
    );

    // Arbitration looks at registered occupancy, giving the two-edge push-to-cmd latency
    assign grant_rd = rd_avail_q && (!wr_avail_q || last_grant_q == RW_WRITE);
    assign wr_pop   = state_q == IDLE && wr_avail_q && !grant_rd;
    assign rd_pop   = state_q == IDLE && grant_rd;

    assign wr_req_ready  = init_q && !wr_full;
    assign rd_req_ready  = init_q && !rd_full;
    assign cmd_valid     = cmd_valid_q;
    assign cmd_rw        = cmd_rw_q;
    assign cmd_addr      = cmd_addr_q;
    assign cmd_wdata     = cmd_wdata_q;
    assign i2c_trigger   = trig_q;
    assign wr_resp_valid = wr_resp_valid_q;
    assign rd_resp_valid = rd_resp_valid_q;
    assign wr_resp_err   = wr_resp_valid_q && err_q;
    assign rd_resp_err   = rd_resp_valid_q && err_q;
    assign rd_resp_data  = rdata_q;
    assign busy          = state_q != IDLE;
    assign pending_wr    = !wr_empty || (busy && cmd_rw_q == RW_WRITE);
    assign pending_rd    = !rd_empty || (busy && cmd_rw_q == RW_READ);

`ifdef I2C_SCHED_TIMEOUT_EN
    logic [15:0] to_cnt_q;
    logic        abort_q;
    assign timeout   = state_q == WAIT && to_cnt_q == 16'(TIMEOUT_CYCLES - 1);
    assign cmd_abort = abort_q;
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            to_cnt_q <= '0;
            abort_q  <= 1'b0;
        end else begin
            to_cnt_q <= state_q == WAIT ? to_cnt_q + 16'd1 : '0;
            abort_q  <= timeout && !done;
        end
    end
`else
    assign timeout   = 1'b0;
    assign cmd_abort = 1'b0;
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q         <= IDLE;
            init_q          <= 1'b0;
            wr_avail_q      <= 1'b0;
            rd_avail_q      <= 1'b0;
            last_grant_q    <= RW_READ;
            cmd_valid_q     <= 1'b0;
            cmd_rw_q        <= RW_WRITE;
            cmd_addr_q      <= '0;
            cmd_wdata_q     <= '0;
            trig_q          <= 1'b0;
            err_q           <= 1'b0;
            rdata_q         <= '0;
            wr_resp_valid_q <= 1'b0;
            rd_resp_valid_q <= 1'b0;
        end else begin
            init_q     <= 1'b1;
            wr_avail_q <= !wr_empty;
            rd_avail_q <= !rd_empty;
            trig_q     <= 1'b0;
            case (state_q)
                IDLE: if (wr_pop || rd_pop) begin
                    state_q      <= ISSUE;
                    cmd_valid_q  <= 1'b1;
                    cmd_rw_q     <= grant_rd;
                    last_grant_q <= grant_rd;
                    cmd_addr_q   <= grant_rd ? rd_head : wr_head[ADDR_W+DATA_W-1:DATA_W];
                    cmd_wdata_q  <= grant_rd ? '0 : wr_head[DATA_W-1:0];
                end
                ISSUE: if (cmd_ready) begin
                    state_q     <= WAIT;
                    cmd_valid_q <= 1'b0;
                    trig_q      <= 1'b1;
                end
                WAIT: if (done || timeout) begin
                    state_q         <= RESP;
                    err_q           <= !done || done_nack;
                    rdata_q         <= (cmd_rw_q == RW_READ && done && !done_nack) ? done_rdata : '0;
                    wr_resp_valid_q <= cmd_rw_q == RW_WRITE;
                    rd_resp_valid_q <= cmd_rw_q == RW_READ;
                end
                RESP: if (cmd_rw_q == RW_READ ? rd_resp_ready : wr_resp_ready) begin
                    state_q         <= IDLE;
                    wr_resp_valid_q <= 1'b0;
                    rd_resp_valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// tb_i2c_txn_scheduler: directed scoreboard bench for i2c_txn_scheduler.
module tb_i2c_txn_scheduler;
    import i2c_sched_pkg::*;
    typedef struct packed { logic rw; wr_req_t req; } exp_cmd_t;
    typedef struct packed { logic rw; logic err; logic [7:0] data; } exp_resp_t;

    logic       ACLK = 1'b0, ARESET = 1'b1;
    logic       wr_req_valid = 1'b0, rd_req_valid = 1'b0, cmd_ready = 1'b0;
    logic [7:0] wr_req_addr = '0, wr_req_data = '0, rd_req_addr = '0, done_rdata = '0;
    logic       done = 1'b0, done_nack = 1'b0, wr_resp_ready = 1'b0, rd_resp_ready = 1'b0;
    logic       wr_req_ready, rd_req_ready, cmd_valid, cmd_rw, i2c_trigger, cmd_abort;
    logic [7:0] cmd_addr, cmd_wdata, rd_resp_data;
    logic       wr_resp_valid, wr_resp_err, rd_resp_valid, rd_resp_err, pending_wr, pending_rd, busy;

    int        errors = 0, checks = 0;
    logic      cur_rw = 1'b0;
    exp_cmd_t  cmd_q[$];
    exp_resp_t resp_q[$];

    always #5 ACLK = ~ACLK;

    i2c_txn_scheduler #(.TIMEOUT_CYCLES(100)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .i2c_trigger(i2c_trigger), .cmd_abort(cmd_abort),
        .done(done), .done_nack(done_nack), .done_rdata(done_rdata),
        .wr_resp_valid(wr_resp_valid), .wr_resp_ready(wr_resp_ready), .wr_resp_err(wr_resp_err),
        .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
        .rd_resp_data(rd_resp_data), .rd_resp_err(rd_resp_err),
        .pending_wr(pending_wr), .pending_rd(pending_rd), .busy(busy)
    );

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req_wr(input logic [7:0] a, input logic [7:0] d);
        exp_cmd_t e;
        e.rw = RW_WRITE; e.req.addr = a; e.req.data = d;
        cmd_q.push_back(e);
        wr_req_valid = 1'b1; wr_req_addr = a; wr_req_data = d;
    endtask

    task automatic req_rd(input logic [7:0] a);
        exp_cmd_t e;
        e.rw = RW_READ; e.req.addr = a; e.req.data = 8'h00;
        cmd_q.push_back(e);
        rd_req_valid = 1'b1; rd_req_addr = a;
    endtask

    task automatic expect_cmd();
        exp_cmd_t e;
        int n = 0;
        while (!cmd_valid && n < 50) begin step(); n++; end
        chk("cmd_valid", cmd_valid, 1);
        e = cmd_q.pop_front();
        cur_rw = e.rw;
        chk("cmd_rw", cmd_rw, e.rw);
        chk("cmd_addr", cmd_addr, e.req.addr);
        chk("cmd_wdata", cmd_wdata, e.req.data);
    endtask

    task automatic handshake(input logic with_done);
        cmd_ready = 1'b1; done = with_done; done_nack = with_done;
        step();
        cmd_ready = 1'b0; done = 1'b0; done_nack = 1'b0;
        chk("i2c_trigger", i2c_trigger, 1);
        chk("cmd_valid_drop", cmd_valid, 0);
        chk("busy_wait", busy, 1);
        step();
        chk("i2c_trigger_pulse", i2c_trigger, 0);
    endtask

    task automatic take_resp();
        exp_resp_t r = resp_q.pop_front();
        chk("wr_resp_valid", wr_resp_valid, !r.rw);
        chk("rd_resp_valid", rd_resp_valid, r.rw);
        chk("wr_resp_err", wr_resp_err, r.rw ? 1'b0 : r.err);
        chk("rd_resp_err", rd_resp_err, r.rw ? r.err : 1'b0);
        chk("rd_resp_data", rd_resp_data, r.data);
        wr_resp_ready = 1'b1; rd_resp_ready = 1'b1;
        step();
        wr_resp_ready = 1'b0; rd_resp_ready = 1'b0;
        chk("resp_released", wr_resp_valid | rd_resp_valid, 0);
    endtask

    task automatic complete(input logic nack, input logic [7:0] rdata);
        exp_resp_t r;
        r.rw = cur_rw; r.err = nack; r.data = (cur_rw && !nack) ? rdata : 8'h00;
        resp_q.push_back(r);
        done = 1'b1; done_nack = nack; done_rdata = rdata;
        step();
        done = 1'b0; done_nack = 1'b0; done_rdata = '0;
        take_resp();
    endtask

    task automatic run_txn(input logic nack, input logic [7:0] rdata);
        expect_cmd();
        handshake(1'b0);
        complete(nack, rdata);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic seen;
        exp_resp_t r;
        // reset
        step(); step();
        chk("rst_wr_ready", wr_req_ready, 0);
        chk("rst_rd_ready", rd_req_ready, 0);
        chk("rst_outputs", {cmd_valid, busy, pending_wr, pending_rd, wr_resp_valid, rd_resp_valid, cmd_abort, i2c_trigger}, 0);
        ARESET = 1'b0;
        step();
        chk("ready_after_rst", {wr_req_ready, rd_req_ready}, 2'b11);
        // single write with latency check
        req_wr(8'h50, 8'hA5);
        step();
        wr_req_valid = 1'b0;
        chk("lat_e0_valid", cmd_valid, 0);
        chk("pending_wr_queued", pending_wr, 1);
        chk("busy_idle", busy, 0);
        step();
        chk("lat_e1_valid", cmd_valid, 0);
        step();
        chk("lat_e2_valid", cmd_valid, 1);
        run_txn(1'b0, 8'h00);
        // single read
        req_rd(8'h51);
        step();
        rd_req_valid = 1'b0;
        chk("pending_rd_queued", pending_rd, 1);
        run_txn(1'b0, 8'h3C);
        // contention
        req_wr(8'h10, 8'h01); req_rd(8'h20);
        step();
        req_wr(8'h11, 8'h02); req_rd(8'h21);
        step();
        wr_req_valid = 1'b0; rd_req_valid = 1'b0;
        cmd_q.delete();
        begin
            exp_cmd_t e;
            e.rw = RW_WRITE; e.req.addr = 8'h10; e.req.data = 8'h01; cmd_q.push_back(e);
            e.rw = RW_READ;  e.req.addr = 8'h20; e.req.data = 8'h00; cmd_q.push_back(e);
            e.rw = RW_WRITE; e.req.addr = 8'h11; e.req.data = 8'h02; cmd_q.push_back(e);
            e.rw = RW_READ;  e.req.addr = 8'h21; e.req.data = 8'h00; cmd_q.push_back(e);
        end
        run_txn(1'b0, 8'h00);
        run_txn(1'b0, 8'h5A);
        run_txn(1'b0, 8'h00);
        run_txn(1'b0, 8'hC3);
        // full write FIFO with cmd_ready held low
        for (int i = 0; i < 5; i++) begin
            req_wr(8'(8'h30 + i), 8'(8'hC0 + i));
            chk("wr_ready_fill", wr_req_ready, 1);
            step();
        end
        req_wr(8'h35, 8'hC5);
        chk("wr_ready_full", wr_req_ready, 0);
        chk("pending_wr_full", pending_wr, 1);
        step(); step(); step();
        chk("wr_ready_still_full", wr_req_ready, 0);
        run_txn(1'b0, 8'h00);
        n = 0;
        while (!wr_req_ready && n < 20) begin step(); n++; end
        chk("wr_ready_after_pop", wr_req_ready, 1);
        step();
        wr_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("pending_wr_drain", pending_wr, 1);
            run_txn(1'b0, 8'h00);
        end
        chk("pending_wr_empty", pending_wr, 0);
        chk("busy_drained", busy, 0);
        // NACK read
        req_rd(8'h60);
        step();
        rd_req_valid = 1'b0;
        run_txn(1'b1, 8'hEE);
        // reset during WAIT
        req_wr(8'h70, 8'h07);
        step();
        wr_req_valid = 1'b0;
        expect_cmd();
        handshake(1'b0);
        rd_req_valid = 1'b1; rd_req_addr = 8'h71;
        step();
        rd_req_valid = 1'b0;
        chk("pending_rd_in_wait", pending_rd, 1);
        ARESET = 1'b1;
        #1;
        chk("midrst_outputs", {cmd_valid, busy, pending_wr, pending_rd, wr_req_ready, rd_req_ready, wr_resp_valid, rd_resp_valid}, 0);
        step();
        ARESET = 1'b0;
        done = 1'b1;
        step();
        done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen |= cmd_valid | wr_resp_valid | rd_resp_valid | busy;
            step();
        end
        chk("no_activity_after_rst", seen, 0);
        // timeout / unbounded WAIT; done coinciding with cmd_ready is ignored
        req_wr(8'h80, 8'h08);
        step();
        wr_req_valid = 1'b0;
        expect_cmd();
        handshake(1'b1);
`ifdef I2C_SCHED_TIMEOUT_EN
        n = 1;
        while (!cmd_abort && n < 300) begin step(); n++; end
        chk("abort_delay", n, 100);
        r.rw = RW_WRITE; r.err = 1'b1; r.data = 8'h00;
        resp_q.push_back(r);
        take_resp();
        chk("abort_pulse", cmd_abort, 0);
`else
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            seen |= wr_resp_valid | rd_resp_valid | cmd_abort;
            step();
        end
        chk("no_timeout_resp", seen, 0);
        chk("busy_unbounded", busy, 1);
        complete(1'b0, 8'h00);
`endif
        chk("final_idle", {busy, pending_wr, pending_rd}, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
